// File: rtl/query_link_pkg.sv
// Shared state encoding and default framing words for the host<->accelerator query link.
package query_link_pkg;

   typedef logic [1:0] state_t;

   localparam state_t StIdle    = 2'd0;
   localparam state_t StCollect = 2'd1;
   localparam state_t StHold    = 2'd2;

   localparam logic [31:0] DEF_SYNC_WORD  = 32'hFFFF_FFFF;
   localparam logic [31:0] DEF_ABORT_WORD = 32'hFFFF_FFFE;

endpackage

// File: rtl/link_fifo.sv
// Synchronous result FIFO with first-word-fall-through head and registered occupancy.
module link_fifo #(
   parameter int unsigned WORD_W = 32,
   parameter int unsigned DEPTH  = 8
) (
   input  logic                         clk_in,
   input  logic                         rst_in,
   input  logic                         push_in,
   input  logic [WORD_W-1:0]            data_in,
   input  logic                         pop_in,
   output logic [WORD_W-1:0]            head_out,
   output logic                         full_out,
   output logic                         empty_out,
   output logic [$clog2(DEPTH+1)-1:0]   count_out
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH+1);

   logic [WORD_W-1:0] mem_q [DEPTH];
   logic [WORD_W-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              do_push, do_pop;

   assign full_out  = (count_q == CNT_W'(DEPTH));
   assign empty_out = (count_q == '0);
   assign count_out = count_q;
   assign head_out  = mem_q[rd_ptr_q];

   // A pop frees a slot in the same cycle, so a push on full is accepted alongside it.
   assign do_pop  = pop_in && !empty_out;
   assign do_push = push_in && (!full_out || do_pop);

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = data_in;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (do_push && !do_pop) begin
         count_d = count_q + 1'b1;
      end else if (do_pop && !do_push) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/query_frame_link.sv
// Reassembles query frames from a change-signalled host register and paces result readback.
module query_frame_link
   import query_link_pkg::*;
#(
   parameter int unsigned        DIM         = 8,
   parameter int unsigned        WORD_W      = 32,
   parameter int unsigned        K_W         = 16,
   parameter logic [WORD_W-1:0]  SYNC_WORD   = DEF_SYNC_WORD,
   parameter logic [WORD_W-1:0]  ABORT_WORD  = DEF_ABORT_WORD,
   parameter int unsigned        RES_DEPTH   = 8,
   parameter int unsigned        PACE_CYCLES = 10_000_000
) (
   input  logic                             clk_in,
   input  logic                             rst_in,
   input  logic [WORD_W-1:0]                host_word_in,
   output logic [WORD_W-1:0]                query_out [DIM],
   output logic [K_W-1:0]                   k_out,
   output logic                             query_valid_out,
   input  logic                             query_ready_in,
   input  logic [WORD_W-1:0]                result_in,
   input  logic                             result_valid_in,
   output logic [WORD_W-1:0]                result_out,
   output logic [WORD_W-1:0]                result_seq_out,
   output logic [$clog2(RES_DEPTH+1)-1:0]   fill_out,
   output logic                             frame_err_out,
   output logic                             ovf_out
);

   localparam int unsigned IDX_W  = $clog2(DIM+1);
   localparam int unsigned PACE_W = $clog2(PACE_CYCLES);
   localparam int unsigned FILL_W = $clog2(RES_DEPTH+1);

   logic [WORD_W-1:0] last_word_q;
   state_t            state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [WORD_W-1:0] query_q [DIM];
   logic [WORD_W-1:0] query_d [DIM];
   logic [K_W-1:0]    k_q, k_d;
   logic              frame_err_q, frame_err_d;
   logic              ovf_q, ovf_d;
   logic [PACE_W-1:0] pace_q, pace_d;
   logic [WORD_W-1:0] result_q, result_d;
   logic [WORD_W-1:0] seq_q, seq_d;

   logic              host_evt, is_sync, is_abort;
   logic              pace_wrap, pop;
   logic              fifo_full, fifo_empty;
   logic [WORD_W-1:0] fifo_head;
   logic [FILL_W-1:0] fifo_count;

   assign host_evt = (host_word_in != last_word_q);
   assign is_sync  = (host_word_in == SYNC_WORD);
   assign is_abort = (host_word_in == ABORT_WORD);

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      query_d     = query_q;
      k_d         = k_q;
      frame_err_d = frame_err_q;
      if (host_evt && is_abort) begin
         state_d = StIdle;
         idx_d   = '0;
      end else begin
         case (state_q)
            StIdle: begin
               if (host_evt && is_sync) begin
                  state_d = StCollect;
                  idx_d   = '0;
               end
            end
            StCollect: begin
               // Sync events are separators only; they let identical consecutive words register.
               if (host_evt && !is_sync) begin
                  if (idx_q < IDX_W'(DIM)) begin
                     for (int unsigned i = 0; i < DIM; i++) begin
                        if (idx_q == IDX_W'(i)) begin
                           query_d[i] = host_word_in;
                        end
                     end
                  end else begin
                     k_d     = host_word_in[K_W-1:0];
                     state_d = StHold;
                  end
                  idx_d = idx_q + 1'b1;
               end
            end
            StHold: begin
               if (host_evt) begin
                  frame_err_d = 1'b1;
               end
               if (query_ready_in) begin
                  state_d = StIdle;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   assign pace_wrap = (pace_q == PACE_W'(PACE_CYCLES - 1));
   assign pop       = pace_wrap && !fifo_empty;

   always_comb begin
      pace_d   = pace_wrap ? '0 : pace_q + 1'b1;
      result_d = result_q;
      seq_d    = seq_q;
      ovf_d    = ovf_q;
      if (pop) begin
         result_d = fifo_head;
         seq_d    = seq_q + 1'b1;
      end
      if (result_valid_in && fifo_full && !pop) begin
         ovf_d = 1'b1;
      end
   end

   link_fifo #(
      .WORD_W (WORD_W),
      .DEPTH  (RES_DEPTH)
   ) u_fifo (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .push_in   (result_valid_in),
      .data_in   (result_in),
      .pop_in    (pop),
      .head_out  (fifo_head),
      .full_out  (fifo_full),
      .empty_out (fifo_empty),
      .count_out (fifo_count)
   );

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         last_word_q <= '0;
         state_q     <= StIdle;
         idx_q       <= '0;
         for (int i = 0; i < int'(DIM); i++) begin
            query_q[i] <= '0;
         end
         k_q         <= '0;
         frame_err_q <= 1'b0;
         ovf_q       <= 1'b0;
         pace_q      <= '0;
         result_q    <= '0;
         seq_q       <= '0;
      end else begin
         last_word_q <= host_word_in;
         state_q     <= state_d;
         idx_q       <= idx_d;
         query_q     <= query_d;
         k_q         <= k_d;
         frame_err_q <= frame_err_d;
         ovf_q       <= ovf_d;
         pace_q      <= pace_d;
         result_q    <= result_d;
         seq_q       <= seq_d;
      end
   end

   assign query_out       = query_q;
   assign k_out           = k_q;
   assign query_valid_out = (state_q == StHold);
   assign result_out      = result_q;
   assign result_seq_out  = seq_q;
   assign fill_out        = fifo_count;
   assign frame_err_out   = frame_err_q;
   assign ovf_out         = ovf_q;

endmodule

// File: tb/tb_query_frame_link.sv
// Scoreboard bench: stimulus queues expected frames/results, a monitor checks them as they appear.
module tb_query_frame_link;

   localparam int unsigned DIM       = 4;
   localparam int unsigned WORD_W    = 32;
   localparam int unsigned K_W       = 16;
   localparam int unsigned RES_DEPTH = 8;
   localparam int unsigned PACE      = 16;
   localparam logic [31:0] SYNC      = 32'hFFFF_FFFF;
   localparam logic [31:0] ABORT     = 32'hFFFF_FFFE;

   typedef struct packed {
      logic [DIM-1:0][31:0] q;
      logic [15:0]          k;
   } frame_t;

   logic              clk = 1'b0;
   logic              rst;
   logic [31:0]       host_word;
   logic [31:0]       query_out [DIM];
   logic [15:0]       k_out;
   logic              query_valid;
   logic              query_ready;
   logic [31:0]       result_in;
   logic              result_valid;
   logic [31:0]       result_out;
   logic [31:0]       result_seq;
   logic [3:0]        fill;
   logic              frame_err;
   logic              ovf;

   frame_t      exp_frames [$];
   logic [31:0] exp_res [$];
   int          errors = 0;
   int          checks = 0;

   query_frame_link #(
      .DIM         (DIM),
      .WORD_W      (WORD_W),
      .K_W         (K_W),
      .SYNC_WORD   (SYNC),
      .ABORT_WORD  (ABORT),
      .RES_DEPTH   (RES_DEPTH),
      .PACE_CYCLES (PACE)
   ) dut (
      .clk_in          (clk),
      .rst_in          (rst),
      .host_word_in    (host_word),
      .query_out       (query_out),
      .k_out           (k_out),
      .query_valid_out (query_valid),
      .query_ready_in  (query_ready),
      .result_in       (result_in),
      .result_valid_in (result_valid),
      .result_out      (result_out),
      .result_seq_out  (result_seq),
      .fill_out        (fill),
      .frame_err_out   (frame_err),
      .ovf_out         (ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic host_put(input logic [31:0] w);
      host_word = w;
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                             input logic [31:0] d, input logic [15:0] k);
      frame_t f;
      f.q[0] = a;
      f.q[1] = b;
      f.q[2] = c;
      f.q[3] = d;
      f.k    = k;
      exp_frames.push_back(f);
      for (int i = 0; i < int'(DIM); i++) begin
         host_put(SYNC);
         host_put(f.q[i]);
      end
      host_put(SYNC);
      host_word = {16'h0, k};
      check("valid_before_k_edge", {31'd0, query_valid}, 32'd0);
      @(posedge clk);
      #1;
      check("valid_after_k_edge", {31'd0, query_valid}, 32'd1);
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic accept();
      check("valid_held_before_ready", {31'd0, query_valid}, 32'd1);
      query_ready = 1'b1;
      @(posedge clk);
      #1;
      query_ready = 1'b0;
      check("valid_low_after_accept", {31'd0, query_valid}, 32'd0);
   endtask

   // Monitor: compares each new frame (valid rise) and each new result (seq change) to the queues.
   initial begin
      logic        prev_valid;
      logic [31:0] prev_seq;
      logic [31:0] exp_seq;
      frame_t      f;
      logic [31:0] r;
      prev_valid = 1'b0;
      prev_seq   = '0;
      exp_seq    = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_valid = 1'b0;
            prev_seq   = '0;
            exp_seq    = '0;
         end else begin
            if (query_valid && !prev_valid) begin
               if (exp_frames.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_frame: got valid=1 expected no frame");
               end else begin
                  f = exp_frames.pop_front();
                  for (int i = 0; i < int'(DIM); i++) begin
                     check("frame_word", query_out[i], f.q[i]);
                  end
                  check("frame_k", {16'h0, k_out}, {16'h0, f.k});
               end
            end
            prev_valid = query_valid;
            if (result_seq != prev_seq) begin
               exp_seq = exp_seq + 1;
               check("result_seq", result_seq, exp_seq);
               if (exp_res.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_result: got %h expected none", result_out);
               end else begin
                  r = exp_res.pop_front();
                  check("result_word", result_out, r);
               end
               prev_seq = result_seq;
            end
         end
      end
   end

   initial begin
      rst          = 1'b1;
      host_word    = '0;
      query_ready  = 1'b0;
      result_in    = '0;
      result_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_valid", {31'd0, query_valid}, 32'd0);
      check("rst_k", {16'h0, k_out}, 32'd0);
      check("rst_query0", query_out[0], 32'd0);
      check("rst_fill", {28'd0, fill}, 32'd0);
      check("rst_seq", result_seq, 32'd0);
      check("rst_result", result_out, 32'd0);
      check("rst_flags", {30'd0, frame_err, ovf}, 32'd0);

      // Basic frame, held with ready low, then accepted.
      send_frame(32'd5, 32'd7, 32'd1, 32'd1, 16'd3);
      accept();

      // Repeated values pass thanks to separators.
      send_frame(32'd9, 32'd9, 32'd9, 32'd9, 16'd2);
      accept();

      // Abort discards a partial frame.
      host_put(SYNC);
      host_put(32'd4);
      host_put(SYNC);
      host_put(32'd6);
      host_put(ABORT);
      check("valid_after_abort", {31'd0, query_valid}, 32'd0);
      send_frame(32'd5, 32'd7, 32'd1, 32'd1, 16'd3);

      // Write during HOLD flags a framing error but keeps the frame.
      host_put(32'h1234);
      check("frame_err_set", {31'd0, frame_err}, 32'd1);
      check("hold_q0", query_out[0], 32'd5);
      check("hold_q1", query_out[1], 32'd7);
      check("hold_q2", query_out[2], 32'd1);
      check("hold_q3", query_out[3], 32'd1);
      check("hold_k", {16'h0, k_out}, 32'd3);
      accept();
      check("frame_err_sticky", {31'd0, frame_err}, 32'd1);

      // Async reset between edges in the middle of COLLECT.
      host_put(SYNC);
      host_put(32'd4);
      host_put(SYNC);
      #2;
      rst = 1'b1;
      #1;
      check("async_q0", query_out[0], 32'd0);
      check("async_k", {16'h0, k_out}, 32'd0);
      check("async_err", {31'd0, frame_err}, 32'd0);
      check("async_valid", {31'd0, query_valid}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      send_frame(32'd2, 32'd4, 32'd6, 32'd8, 16'd5);
      accept();

      // Result FIFO: pacer phase is fixed by this reset, first pop at the 16th edge.
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         result_in    = i;
         result_valid = 1'b1;
         if (i <= 8) exp_res.push_back(i);
         @(posedge clk);
         #1;
      end
      result_valid = 1'b0;
      check("fill_full", {28'd0, fill}, 32'd8);
      check("ovf_set", {31'd0, ovf}, 32'd1);
      repeat (5) @(posedge clk);
      #1;
      check("fill_before_pop", {28'd0, fill}, 32'd8);
      check("seq_before_pop", result_seq, 32'd0);
      result_in    = 32'd99;
      result_valid = 1'b1;
      exp_res.push_back(32'd99);
      @(posedge clk);
      #1;
      result_valid = 1'b0;
      check("fill_push_pop_full", {28'd0, fill}, 32'd8);
      check("first_pop", result_out, 32'd1);
      for (int n = 0; n < 300 && exp_res.size() != 0; n++) begin
         @(posedge clk);
         #1;
      end
      checks++;
      if (exp_res.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout: got %0d left expected 0", exp_res.size());
      end
      repeat (40) @(posedge clk);
      #1;
      check("seq_final", result_seq, 32'd9);
      check("result_final", result_out, 32'd99);
      check("fill_empty", {28'd0, fill}, 32'd0);
      check("ovf_sticky", {31'd0, ovf}, 32'd1);
      checks++;
      if (exp_frames.size() != 0) begin
         errors++;
         $display("FAIL frames_outstanding: got %0d expected 0", exp_frames.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
